// File: rtl/mpaddsub_pkg.sv
// Shared types and elaboration-time helpers for the iterative multi-precision adder/subtractor.
package mpaddsub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic int ceil_div(input int n, input int d);
    return (n + d - 1) / d;
  endfunction

  // Limb counter width; never below one bit so a single-limb build still has a counter.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mp_limb_adder.sv
// Combinational LIMB-bit adder with optional inversion of b (used for A + ~B + 1).
module mp_limb_adder #(
  parameter int LIMB = 128
) (
  input  logic [LIMB-1:0] a,
  input  logic [LIMB-1:0] b,
  input  logic            cin,
  input  logic            inv_b,
  output logic [LIMB-1:0] sum,
  output logic            cout
);

  logic [LIMB-1:0] bx;

  generate
    for (genvar gi = 0; gi < LIMB; gi++) begin : g_inv
      assign bx[gi] = b[gi] ^ inv_b;
    end
  endgenerate

  assign {cout, sum} = {1'b0, a} + {1'b0, bx} + {{LIMB{1'b0}}, cin};

endmodule

// File: rtl/mpaddsub_iter.sv
// Iterative A+B / A-B over WIDTH bits, one LIMB-bit limb per clock, LSB limb first.
module mpaddsub_iter
  import mpaddsub_pkg::*;
#(
  parameter int WIDTH = 514,
  parameter int LIMB  = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             subtract,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH:0]   C,
  output logic             done,
  output logic             busy
);

  localparam int NLIMB = ceil_div(WIDTH, LIMB);
  localparam int PW    = NLIMB * LIMB;
  localparam int CW    = cnt_width(NLIMB);
  localparam logic [CW-1:0] LAST = CW'(NLIMB - 1);
  localparam bit PADDED = (PW != WIDTH);

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic [PW-1:0]   a_q;
  logic [PW-1:0]   b_q;
  logic [PW-1:0]   acc_q;
  logic            sub_q;
  logic            carry_q;
  logic [WIDTH:0]  c_q;
  logic            done_q;
  logic            busy_q;

  logic [LIMB-1:0] limb_sum;
  logic            limb_cout;
  logic [PW-1:0]   acc_d;
  logic            msb_d;
  logic [WIDTH:0]  c_d;

  mp_limb_adder #(.LIMB(LIMB)) u_adder (
    .a     (a_q[LIMB-1:0]),
    .b     (b_q[LIMB-1:0]),
    .cin   (carry_q),
    .inv_b (sub_q),
    .sum   (limb_sum),
    .cout  (limb_cout)
  );

  // New limb enters the accumulator from the top; after NLIMB limbs it is aligned.
  assign acc_d = PW'({limb_sum, acc_q} >> LIMB);

  // With padding, bit WIDTH of the padded result is both carry (add) and borrow (sub);
  // without padding the carry-out is used, inverted to a borrow when subtracting.
  generate
    if (PADDED) begin : g_pad
      assign msb_d = acc_d[WIDTH];
    end else begin : g_nopad
      assign msb_d = limb_cout ^ sub_q;
    end
  endgenerate

  assign c_d = {msb_d, acc_d[WIDTH-1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      sub_q   <= 1'b0;
      carry_q <= 1'b0;
      c_q     <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q     <= PW'(A);
            b_q     <= PW'(B);
            sub_q   <= subtract;
            carry_q <= subtract;
            cnt_q   <= '0;
            acc_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_RUN;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_RUN: begin
          a_q     <= a_q >> LIMB;
          b_q     <= b_q >> LIMB;
          acc_q   <= acc_d;
          carry_q <= limb_cout;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            c_q     <= c_d;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_DONE;
          end
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign C    = c_q;
  assign done = done_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_mpaddsub_iter.sv
// Runs five configurations of mpaddsub_iter in lockstep on shared stimulus and checks each against an arithmetic model.
module tb_mpaddsub_iter;

  logic         clk;
  logic         rst;
  logic         start;
  logic         subtract;
  logic [513:0] a_bus;
  logic [513:0] b_bus;

  logic [514:0] c0;
  logic [514:0] c1;
  logic [16:0]  c2;
  logic [10:0]  c3;
  logic [10:0]  c4;
  logic         done_all [5];
  logic         busy_all [5];
  logic [514:0] c_all    [5];

  localparam int W_T  [5] = '{514, 514, 16, 10, 10};
  localparam int NL_T [5] = '{5, 1, 4, 4, 3};

  int total;
  int bad;

  mpaddsub_iter #(.WIDTH(514), .LIMB(128)) u0 (
    .clk(clk), .rst(rst), .start(start), .subtract(subtract),
    .A(a_bus[513:0]), .B(b_bus[513:0]), .C(c0), .done(done_all[0]), .busy(busy_all[0]));
  mpaddsub_iter #(.WIDTH(514), .LIMB(514)) u1 (
    .clk(clk), .rst(rst), .start(start), .subtract(subtract),
    .A(a_bus[513:0]), .B(b_bus[513:0]), .C(c1), .done(done_all[1]), .busy(busy_all[1]));
  mpaddsub_iter #(.WIDTH(16), .LIMB(4)) u2 (
    .clk(clk), .rst(rst), .start(start), .subtract(subtract),
    .A(a_bus[15:0]), .B(b_bus[15:0]), .C(c2), .done(done_all[2]), .busy(busy_all[2]));
  mpaddsub_iter #(.WIDTH(10), .LIMB(3)) u3 (
    .clk(clk), .rst(rst), .start(start), .subtract(subtract),
    .A(a_bus[9:0]), .B(b_bus[9:0]), .C(c3), .done(done_all[3]), .busy(busy_all[3]));
  mpaddsub_iter #(.WIDTH(10), .LIMB(4)) u4 (
    .clk(clk), .rst(rst), .start(start), .subtract(subtract),
    .A(a_bus[9:0]), .B(b_bus[9:0]), .C(c4), .done(done_all[4]), .busy(busy_all[4]));

  assign c_all[0] = c0;
  assign c_all[1] = c1;
  assign c_all[2] = 515'(c2);
  assign c_all[3] = 515'(c3);
  assign c_all[4] = 515'(c4);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain unsigned arithmetic on the operands truncated to w bits.
  function automatic logic [514:0] ref_c(input int w, input logic sub,
                                         input logic [513:0] a, input logic [513:0] b);
    logic [515:0] mask;
    logic [515:0] aa;
    logic [515:0] bb;
    logic [515:0] r;
    mask = (516'd1 << w) - 516'd1;
    aa = {2'b00, a} & mask;
    bb = {2'b00, b} & mask;
    if (!sub) begin
      r = aa + bb;
    end else begin
      r = (aa - bb) & mask;
      if (aa < bb) r = r | (516'd1 << w);
    end
    return r[514:0];
  endfunction

  function automatic logic [513:0] rnd_op();
    logic [513:0] v;
    v = '0;
    for (int k = 0; k < 17; k++) v = {v[481:0], 32'($urandom)};
    case ($urandom_range(0, 7))
      0: v = '1;
      1: v = '0;
      2: v = 514'($urandom_range(0, 15));
      default: ;
    endcase
    return v;
  endfunction

  task automatic chk(input string nm, input logic [514:0] act, input logic [514:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // One transaction on all instances: done/busy timing per cycle, then result.
  task automatic run_txn(input logic sub, input logic [513:0] a, input logic [513:0] b);
    start = 1'b1; subtract = sub; a_bus = a; b_bus = b;
    @(posedge clk); #1;
    start = 1'b0; subtract = ~sub; a_bus = rnd_op(); b_bus = rnd_op();
    for (int j = 0; j <= 6; j++) begin
      if (j > 0) begin
        @(posedge clk); #1;
      end
      for (int i = 0; i < 5; i++) begin
        chk($sformatf("inst%0d done j=%0d", i, j), 515'(done_all[i]), 515'(j == NL_T[i]));
        chk($sformatf("inst%0d busy j=%0d", i, j), 515'(busy_all[i]), 515'(j < NL_T[i]));
      end
    end
    for (int i = 0; i < 5; i++)
      chk($sformatf("inst%0d C", i), c_all[i], ref_c(W_T[i], sub, a, b));
    $display("txn sub=%0d a=%h b=%h C0=%h", sub, a, b, c_all[0]);
  endtask

  typedef struct {
    logic         sub;
    logic [513:0] a;
    logic [513:0] b;
    logic [514:0] exp514;
    logic [16:0]  exp16;
  } vec_t;

  vec_t vecs [5];

  initial begin
    logic [513:0] ones;
    logic [514:0] exp1;
    logic [514:0] exp2;
    ones = '1;
    total = 0;
    bad = 0;
    start = 1'b0;
    subtract = 1'b0;
    a_bus = '0;
    b_bus = '0;

    vecs[0] = '{1'b0, ones, 514'd1, {1'b1, 514'b0}, 17'h10000};
    vecs[1] = '{1'b1, 514'd5, 514'd7, {1'b1, {513{1'b1}}, 1'b0}, 17'h1FFFE};
    vecs[2] = '{1'b1, 514'd7, 514'd5, 515'd2, 17'h00002};
    vecs[3] = '{1'b0, 514'd0, 514'd0, 515'd0, 17'h00000};
    vecs[4] = '{1'b0, 514'hFFFF, 514'hFFFF, 515'h1FFFE, 17'h1FFFE};

    rst = 1'b1;
    #12;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("reset inst%0d C", i), c_all[i], 515'd0);
      chk($sformatf("reset inst%0d done", i), 515'(done_all[i]), 515'd0);
      chk($sformatf("reset inst%0d busy", i), 515'(busy_all[i]), 515'd0);
    end
    rst = 1'b0;
    @(posedge clk); #1;

    for (int v = 0; v < 5; v++) begin
      run_txn(vecs[v].sub, vecs[v].a, vecs[v].b);
      chk($sformatf("vec%0d C514", v), c_all[0], vecs[v].exp514);
      chk($sformatf("vec%0d C16", v), c_all[2], 515'(vecs[v].exp16));
    end

    // Back-to-back on the 5-limb instance; first result must hold until the second DONE.
    exp1 = ref_c(514, 1'b0, ones, 514'd1);
    exp2 = ref_c(514, 1'b1, 514'd5, 514'd7);
    start = 1'b1; subtract = 1'b0; a_bus = ones; b_bus = 514'd1;
    @(posedge clk); #1;
    start = 1'b0; a_bus = rnd_op(); b_bus = rnd_op();
    for (int j = 1; j <= 5; j++) begin
      @(posedge clk); #1;
      chk($sformatf("b2b first done j=%0d", j), 515'(done_all[0]), 515'(j == 5));
    end
    chk("b2b first C", c_all[0], exp1);
    start = 1'b1; subtract = 1'b1; a_bus = 514'd5; b_bus = 514'd7;
    for (int j = 1; j <= 6; j++) begin
      @(posedge clk); #1;
      if (j == 1) begin
        start = 1'b0; a_bus = rnd_op(); b_bus = rnd_op();
      end
      chk($sformatf("b2b second done j=%0d", j), 515'(done_all[0]), 515'(j == 6));
      chk($sformatf("b2b C j=%0d", j), c_all[0], (j == 6) ? exp2 : exp1);
    end
    $display("txn back-to-back C0=%h", c_all[0]);
    repeat (3) @(posedge clk);
    #1;
    run_txn(vecs[4].sub, vecs[4].a, vecs[4].b);

    // Asynchronous reset mid-RUN: outputs clear at once and no done follows.
    start = 1'b1; subtract = 1'b0; a_bus = rnd_op(); b_bus = rnd_op();
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("midrst inst%0d C", i), c_all[i], 515'd0);
      chk($sformatf("midrst inst%0d done", i), 515'(done_all[i]), 515'd0);
      chk($sformatf("midrst inst%0d busy", i), 515'(busy_all[i]), 515'd0);
    end
    #1;
    rst = 1'b0;
    for (int j = 0; j < 8; j++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 5; i++)
        chk($sformatf("midrst inst%0d no done j=%0d", i, j), 515'(done_all[i]), 515'd0);
    end
    $display("txn mid-run reset");

    for (int n = 0; n < 1500; n++)
      run_txn(1'($urandom_range(0, 1)), rnd_op(), rnd_op());

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
